shifter_bus_sequencer: RTL and testbench

- Drives the shifter's bus-side pins (de, cs, load, rw, addr, data) from a single CLOCK_32 domain.
- Performs the power-up shifter reset pulse and the 3-load priming sequence, then produces per-scanline DE windows.
- Issues one /LOAD per 16-clock slot, fed from a video word stream.
- Interleaves CPU-side register writes (palette, resolution) into slot phases that never collide with loads.

---
 rtl/shifter_bus_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_shifter_bus_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_bus_sequencer.sv
// ---------------------------------------------------------------------------
// shifter_bus_sequencer
//   Drives the video shifter's bus-side pins from the CLOCK_32 domain.
//   After reset: one-clock shifter reset pulse (cs+load low), PRIME_LOADS
//   dummy loads with DE high, GAP_SLOTS of DE low, then free-running
//   scanlines. Each line is LINE_SLOTS slots of SLOT_CLKS clocks. Slots
//   1..ACTIVE_SLOTS each carry one /LOAD fed from the video word stream.
//   CPU register writes use phases 1..3 of any RUN slot, which is clear of
//   the fetch/load phases LOAD_PHASE-1..LOAD_PHASE+3.
//
// Ports
//   CLOCK_32, reset        clock, async active-high reset
//   vid_data/valid/ready   video word stream (ready = one-clock pop)
//   reg_req/addr/data/ack  register write handshake (req held until ack)
//   de, cs, load, rw       shifter control pins (cs, load active low)
//   addr, data_out,data_oe shifter register address / bus data / drive enable
//   line_start             pulse at phase 0 of slot 0 of every RUN line
//   underrun               pulse when a load slot finds no video word
// ---------------------------------------------------------------------------
module shifter_bus_sequencer #(
   parameter int SLOT_CLKS    = 16,
   parameter int ACTIVE_SLOTS = 80,
   parameter int LINE_SLOTS   = 128,
   parameter int PRIME_LOADS  = 3,
   parameter int GAP_SLOTS    = 6,
   parameter int LOAD_PHASE   = 8
) (
   input  logic        CLOCK_32,
   input  logic        reset,
   input  logic [15:0] vid_data,
   input  logic        vid_valid,
   output logic        vid_ready,
   input  logic        reg_req,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] reg_data,
   output logic        reg_ack,
   output logic        de,
   output logic        cs,
   output logic        load,
   output logic        rw,
   output logic [4:0]  addr,
   output logic [15:0] data_out,
   output logic        data_oe,
   output logic        line_start,
   output logic        underrun
);

   localparam int PHASE_W = $clog2(SLOT_CLKS);
   localparam int SLOT_W  = $clog2(LINE_SLOTS);
   localparam int PRIME_W = $clog2(PRIME_LOADS + 1);

   typedef enum logic [1:0] {
      ST_RST_PULSE,
      ST_PRIME,
      ST_GAP,
      ST_RUN
   } state_t;

   state_t              r_state;
   logic [PHASE_W-1:0]  r_phase;
   logic [SLOT_W-1:0]   r_slot;
   logic [PRIME_W-1:0]  r_prime;
   logic                r_wr_pend;
   logic [4:0]          r_wr_addr;
   logic [15:0]         r_wr_data;
   logic [15:0]         r_vid_word;

   // The counters describe the cycle whose outputs are registered at the
   // coming edge, so every pin below is a pure flop output.
   logic w_last_phase;
   logic w_load_win;
   logic w_fetch;
   logic w_load_slot;
   logic w_de_slot;

   assign w_last_phase = (r_phase == PHASE_W'(SLOT_CLKS - 1));
   assign w_load_win   = (r_phase >= PHASE_W'(LOAD_PHASE)) &&
                         (r_phase <= PHASE_W'(LOAD_PHASE + 3));
   assign w_fetch      = (r_phase == PHASE_W'(LOAD_PHASE - 1));
   assign w_load_slot  = (r_slot != '0) && (r_slot <= SLOT_W'(ACTIVE_SLOTS));
   assign w_de_slot    = (r_slot <= SLOT_W'(ACTIVE_SLOTS));

   always_ff @(posedge CLOCK_32 or posedge reset) begin
      if (reset) begin
         r_state    <= ST_RST_PULSE;
         r_phase    <= '0;
         r_slot     <= '0;
         r_prime    <= '0;
         r_wr_pend  <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_vid_word <= '0;
         de         <= 1'b0;
         cs         <= 1'b1;
         load       <= 1'b1;
         rw         <= 1'b1;
         addr       <= '0;
         data_out   <= '0;
         data_oe    <= 1'b0;
         vid_ready  <= 1'b0;
         reg_ack    <= 1'b0;
         line_start <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         // idle bus unless a load or write phase overrides below
         cs         <= 1'b1;
         load       <= 1'b1;
         rw         <= 1'b1;
         data_oe    <= 1'b0;
         vid_ready  <= 1'b0;
         reg_ack    <= 1'b0;
         line_start <= 1'b0;
         underrun   <= 1'b0;
         r_phase    <= r_phase + 1'b1;

         case (r_state)
            ST_RST_PULSE: begin
               de <= 1'b0;
               if (r_phase == '0) begin
                  cs   <= 1'b0;
                  load <= 1'b0;
               end else begin
                  r_state <= ST_PRIME;
                  r_phase <= '0;
               end
            end

            ST_PRIME: begin
               de <= 1'b1;
               if (w_load_win) begin
                  load     <= 1'b0;
                  data_out <= '0;
                  data_oe  <= 1'b1;
               end
               if (w_last_phase) begin
                  if (r_prime == PRIME_W'(PRIME_LOADS - 1)) begin
                     r_state <= ST_GAP;
                     r_prime <= '0;
                     r_slot  <= '0;
                  end else begin
                     r_prime <= r_prime + 1'b1;
                  end
               end
            end

            ST_GAP: begin
               de <= 1'b0;
               if (w_last_phase) begin
                  if (r_slot == SLOT_W'(GAP_SLOTS - 1)) begin
                     r_state <= ST_RUN;
                     r_slot  <= '0;
                  end else begin
                     r_slot <= r_slot + 1'b1;
                  end
               end
            end

            ST_RUN: begin
               de         <= w_de_slot;
               line_start <= (r_slot == '0) && (r_phase == '0);

               // Fetch one clock ahead of the load window; a missing word
               // still produces a load, just with zero data.
               if (w_load_slot && w_fetch) begin
                  if (vid_valid) begin
                     vid_ready  <= 1'b1;
                     r_vid_word <= vid_data;
                  end else begin
                     underrun   <= 1'b1;
                     r_vid_word <= '0;
                  end
               end
               if (w_load_slot && w_load_win) begin
                  load     <= 1'b0;
                  data_out <= r_vid_word;
                  data_oe  <= 1'b1;
               end

               // Register write: sample at phase 0, strobe phase 1,
               // ack + data hold phase 2, release phase 3 (addr holds).
               if (r_phase == '0) begin
                  r_wr_pend <= reg_req;
                  if (reg_req) begin
                     r_wr_addr <= reg_addr;
                     r_wr_data <= reg_data;
                  end
               end
               if (r_phase == PHASE_W'(1) && r_wr_pend) begin
                  cs       <= 1'b0;
                  rw       <= 1'b0;
                  addr     <= r_wr_addr;
                  data_out <= r_wr_data;
                  data_oe  <= 1'b1;
               end
               if (r_phase == PHASE_W'(2) && r_wr_pend) begin
                  data_oe   <= 1'b1;
                  reg_ack   <= 1'b1;
                  r_wr_pend <= 1'b0;
               end

               if (w_last_phase)
                  r_slot <= (r_slot == SLOT_W'(LINE_SLOTS - 1)) ? '0 : r_slot + 1'b1;
            end

            default: r_state <= ST_RST_PULSE;
         endcase
      end
   end

endmodule

// File: tb/tb_shifter_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shifter_bus_sequencer
//   Self-checking bench. Control pins are compared every cycle against a
//   cycle-index model; video words popped by the DUT are queued and checked
//   against data_out in the matching load window.
// ---------------------------------------------------------------------------
module tb_shifter_bus_sequencer;

   logic        CLOCK_32 = 1'b0;
   logic        reset    = 1'b1;
   logic [15:0] vid_data = 16'h6C6C;
   logic        vid_valid = 1'b1;
   logic        vid_ready;
   logic        reg_req  = 1'b0;
   logic [4:0]  reg_addr = 5'h00;
   logic [15:0] reg_data = 16'h0000;
   logic        reg_ack;
   logic        de, cs, load, rw;
   logic [4:0]  addr;
   logic [15:0] data_out;
   logic        data_oe, line_start, underrun;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          wi    = 0;
   logic [15:0] exp_q[$];
   logic [8:0]  obs;

   localparam logic [8:0] RST_VEC = 9'b0_1_1_1_0_0_0_0_0;

   shifter_bus_sequencer dut (
      .CLOCK_32   (CLOCK_32),
      .reset      (reset),
      .vid_data   (vid_data),
      .vid_valid  (vid_valid),
      .vid_ready  (vid_ready),
      .reg_req    (reg_req),
      .reg_addr   (reg_addr),
      .reg_data   (reg_data),
      .reg_ack    (reg_ack),
      .de         (de),
      .cs         (cs),
      .load       (load),
      .rw         (rw),
      .addr       (addr),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .line_start (line_start),
      .underrun   (underrun)
   );

   // {de, cs, load, rw, data_oe, line_start, vid_ready, underrun, reg_ack}
   assign obs = {de, cs, load, rw, data_oe, line_start, vid_ready, underrun, reg_ack};

   always #5 CLOCK_32 = ~CLOCK_32;

   // cycle index: 1 = first edge after reset release
   always @(posedge CLOCK_32 or posedge reset) begin
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
   end

   // video source: word popped on vid_ready is the expected load data
   always @(posedge CLOCK_32) begin
      if (!reset && vid_ready === 1'b1) begin
         exp_q.push_back(vid_data);
         #1;
         wi = wi + 1;
         vid_data = wi[0] ? 16'h0156 : 16'h6C6C;
      end
   end

   function automatic int cy(input int l, input int s, input int p);
      return 147 + 2048 * l + 16 * s + p;
   endfunction

   // Expected control pins for cycle c with no writes and vid_valid high.
   function automatic logic [8:0] exp_ctl(input int c);
      logic x_de = 1'b0, x_cs = 1'b1, x_ld = 1'b1, x_oe = 1'b0, x_ls = 1'b0, x_vr = 1'b0;
      int r, s, p;
      if (c == 1) begin
         x_cs = 1'b0; x_ld = 1'b0;
      end else if (c >= 3 && c <= 50) begin
         p = (c - 3) % 16;
         x_de = 1'b1;
         if (p >= 8 && p <= 11) begin x_ld = 1'b0; x_oe = 1'b1; end
      end else if (c >= 147) begin
         r = (c - 147) % 2048;
         s = r / 16;
         p = r % 16;
         x_de = (s <= 80);
         x_ls = (r == 0);
         if (s >= 1 && s <= 80) begin
            if (p == 7) x_vr = 1'b1;
            if (p >= 8 && p <= 11) begin x_ld = 1'b0; x_oe = 1'b1; end
         end
      end
      return {x_de, x_cs, x_ld, 1'b1, x_oe, x_ls, x_vr, 1'b0, 1'b0};
   endfunction

   task automatic test_reset;
      @(negedge CLOCK_32);
      total++;
      if (obs !== RST_VEC) begin
         bad++; $display("FAIL reset_ctl: got %b want %b", obs, RST_VEC);
      end
      total++;
      if (addr !== 5'h00) begin
         bad++; $display("FAIL reset_addr: got %h want 00", addr);
      end
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL reset_data: got %h want 0000", data_out);
      end
   endtask

   task automatic test_power_up;
      logic [8:0]  e;
      logic [15:0] w;
      reset = 1'b0;
      while (cyc < 600) begin
         @(negedge CLOCK_32);
         e = exp_ctl(cyc);
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL pwr_ctl cyc=%0d: got %b want %b", cyc, obs, e);
         end
         if (cyc >= 3 && cyc <= 50 && !e[6]) begin
            total++;
            if (data_out !== 16'h0000) begin
               bad++; $display("FAIL prime_data cyc=%0d: got %h want 0000", cyc, data_out);
            end
         end
         if (cyc >= 147 && !e[6] && ((cyc - 147) % 16) == 8) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL pwr_load_data cyc=%0d: got %h, no word popped", cyc, data_out);
            end else begin
               w = exp_q.pop_front();
               if (data_out !== w) begin
                  bad++; $display("FAIL pwr_load_data cyc=%0d: got %h want %h", cyc, data_out, w);
               end
            end
         end
      end
   endtask

   task automatic test_run_lines;
      logic [8:0]  e;
      logic [15:0] w;
      logic        prev_ld = 1'b1;
      int n_ld = 0, n_vr = 0, n_de = 0, t_ls = -1, t_ld = -1;
      while (cyc < cy(1, 127, 15)) begin
         @(negedge CLOCK_32);
         e = exp_ctl(cyc);
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL run_ctl cyc=%0d: got %b want %b", cyc, obs, e);
         end
         if (!e[6] && ((cyc - 147) % 16) == 8) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL run_load_data cyc=%0d: got %h, no word popped", cyc, data_out);
            end else begin
               w = exp_q.pop_front();
               if (data_out !== w) begin
                  bad++; $display("FAIL run_load_data cyc=%0d: got %h want %h", cyc, data_out, w);
               end
            end
         end
         if (cyc >= cy(1, 0, 0)) begin
            if (line_start === 1'b1 && t_ls < 0) t_ls = cyc;
            if (load === 1'b0 && prev_ld === 1'b1) begin
               n_ld++;
               if (t_ld < 0) t_ld = cyc;
            end
            if (vid_ready === 1'b1) n_vr++;
            if (de === 1'b1) n_de++;
         end
         prev_ld = load;
      end
      total++;
      if (n_ld != 80) begin bad++; $display("FAIL loads_per_line: got %0d want 80", n_ld); end
      total++;
      if (n_vr != 80) begin bad++; $display("FAIL pops_per_line: got %0d want 80", n_vr); end
      total++;
      if (n_de != 1296) begin bad++; $display("FAIL de_clocks: got %0d want 1296", n_de); end
      total++;
      if (t_ld - t_ls != 24) begin
         bad++; $display("FAIL first_load_lead: got %0d want 24", t_ld - t_ls);
      end
   endtask

   task automatic test_reg_write;
      logic [8:0] e;
      int s, p;
      while (cyc < cy(2, 10, 12)) @(negedge CLOCK_32);
      reg_addr = 5'h0F; reg_data = 16'h0FFF; reg_req = 1'b1;
      while (cyc < cy(2, 12, 15)) begin
         @(negedge CLOCK_32);
         s = ((cyc - 147) % 2048) / 16;
         p = (cyc - 147) % 16;
         e = exp_ctl(cyc);
         if (s == 11 && p == 1) begin e[7] = 1'b0; e[5] = 1'b0; e[4] = 1'b1; end
         if (s == 11 && p == 2) begin e[4] = 1'b1; e[0] = 1'b1; end
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL wr_ctl slot=%0d ph=%0d: got %b want %b", s, p, obs, e);
         end
         if (s == 11 && (p == 1 || p == 3)) begin
            total++;
            if (addr !== 5'h0F) begin
               bad++; $display("FAIL wr_addr ph=%0d: got %h want 0f", p, addr);
            end
         end
         if (s == 11 && p == 1) begin
            total++;
            if (data_out !== 16'h0FFF) begin
               bad++; $display("FAIL wr_data: got %h want 0fff", data_out);
            end
         end
         if (reg_ack === 1'b1) reg_req = 1'b0;
      end
   endtask

   task automatic test_back_to_back;
      logic [8:0] e;
      int s, p, nack = 0, ack1 = 0, ack2 = 0;
      while (cyc < cy(2, 39, 12)) @(negedge CLOCK_32);
      reg_addr = 5'h00; reg_data = 16'h0000; reg_req = 1'b1;
      while (cyc < cy(2, 42, 15)) begin
         @(negedge CLOCK_32);
         s = ((cyc - 147) % 2048) / 16;
         p = (cyc - 147) % 16;
         e = exp_ctl(cyc);
         if ((s == 40 || s == 41) && p == 1) begin e[7] = 1'b0; e[5] = 1'b0; e[4] = 1'b1; end
         if ((s == 40 || s == 41) && p == 2) begin e[4] = 1'b1; e[0] = 1'b1; end
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL b2b_ctl slot=%0d ph=%0d: got %b want %b", s, p, obs, e);
         end
         if (s == 40 && p == 1) begin
            total++;
            if ({addr, data_out} !== {5'h00, 16'h0000}) begin
               bad++; $display("FAIL b2b_first: got %h/%h want 00/0000", addr, data_out);
            end
         end
         if (s == 41 && p == 1) begin
            total++;
            if ({addr, data_out} !== {5'h10, 16'h0004}) begin
               bad++; $display("FAIL b2b_second: got %h/%h want 10/0004", addr, data_out);
            end
         end
         if (reg_ack === 1'b1) begin
            nack++;
            if (nack == 1) begin
               ack1 = cyc; reg_addr = 5'h10; reg_data = 16'h0004;
            end else begin
               ack2 = cyc; reg_req = 1'b0;
            end
         end
      end
      total++;
      if (nack != 2) begin bad++; $display("FAIL b2b_ack_count: got %0d want 2", nack); end
      total++;
      if (ack2 - ack1 != 16) begin
         bad++; $display("FAIL b2b_ack_spacing: got %0d want 16", ack2 - ack1);
      end
   endtask

   task automatic test_underrun;
      logic [8:0]  e;
      logic [15:0] w;
      int s, p, nur = 0;
      while (cyc < cy(3, 18, 12)) @(negedge CLOCK_32);
      exp_q.delete();
      while (cyc < cy(3, 22, 15)) begin
         @(negedge CLOCK_32);
         s = ((cyc - 147) % 2048) / 16;
         p = (cyc - 147) % 16;
         e = exp_ctl(cyc);
         if (s == 20 && p == 7) begin e[2] = 1'b0; e[1] = 1'b1; end
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL ur_ctl slot=%0d ph=%0d: got %b want %b", s, p, obs, e);
         end
         if (underrun === 1'b1) nur++;
         if (!e[6] && p == 8) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL ur_load_data slot=%0d: got %h, no word queued", s, data_out);
            end else begin
               w = exp_q.pop_front();
               if (data_out !== w) begin
                  bad++; $display("FAIL ur_load_data slot=%0d: got %h want %h", s, data_out, w);
               end
            end
         end
         if (s == 20 && p == 3) begin vid_valid = 1'b0; exp_q.push_back(16'h0000); end
         if (s == 20 && p == 8) vid_valid = 1'b1;
      end
      total++;
      if (nur != 1) begin bad++; $display("FAIL ur_count: got %0d want 1", nur); end
   endtask

   task automatic test_reset_mid_write;
      logic [8:0] e;
      while (cyc < cy(4, 30, 12)) @(negedge CLOCK_32);
      reg_addr = 5'h05; reg_data = 16'hA5A5; reg_req = 1'b1;
      while (cyc < cy(4, 31, 1)) @(negedge CLOCK_32);
      total++;
      if ({cs, rw, data_oe} !== 3'b001) begin
         bad++; $display("FAIL pre_rst_write: got cs/rw/oe=%b want 001", {cs, rw, data_oe});
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (obs !== RST_VEC) begin
         bad++; $display("FAIL rst_async: got %b want %b", obs, RST_VEC);
      end
      repeat (2) begin
         @(negedge CLOCK_32);
         total++;
         if (obs !== RST_VEC) begin
            bad++; $display("FAIL rst_hold: got %b want %b", obs, RST_VEC);
         end
      end
      reset = 1'b0;
      while (cyc < 160) begin
         @(negedge CLOCK_32);
         e = exp_ctl(cyc);
         if (cyc == 148) begin e[7] = 1'b0; e[5] = 1'b0; e[4] = 1'b1; end
         if (cyc == 149) begin e[4] = 1'b1; e[0] = 1'b1; end
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL restart_ctl cyc=%0d: got %b want %b", cyc, obs, e);
         end
         if (cyc == 148) begin
            total++;
            if ({addr, data_out} !== {5'h05, 16'hA5A5}) begin
               bad++; $display("FAIL restart_write: got %h/%h want 05/a5a5", addr, data_out);
            end
         end
         if (reg_ack === 1'b1) reg_req = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(negedge CLOCK_32);
      test_reset;
      test_power_up;
      test_run_lines;
      test_reg_write;
      test_back_to_back;
      test_underrun;
      test_reset_mid_write;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
